// File: rtl/lsu_dram_master.sv
// ---------------------------------------------------------------------------
// lsu_dram_master
//
// Load/store initiator for the single-port DRAM bus. It takes one byte,
// half or word request at a time from the memory stage and turns it into
// word-aligned bus accesses with lane-shifted write data and byte masks. It
// returns sign- or zero-extended load data over a valid/ready response.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : requests that straddle a word boundary run two accesses
//               (ACC0 then ACC1) and complete normally.
//   undefined : ACC1 is not built; straddling requests come back with
//               resp_err=1 and never touch the bus.
//
// Parameters
//   ADDR_W        width of req_addr / dram_addr (default 32)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     request present            (in)
//   req_ready     request accepted on v&r    (out, high only in IDLE)
//   req_wen       1 = store, 0 = load        (in)
//   req_size      00 byte, 01 half, 10 word, 11 reserved (in)
//   req_unsigned  zero-extend loads          (in)
//   req_addr      byte address               (in)
//   req_wdata     right-justified store data (in)
//   resp_valid    response present           (out)
//   resp_ready    response consumed on v&r   (in)
//   resp_rdata    extended load data, 0 for stores/errors (out)
//   resp_err      request rejected, no bus access made    (out)
//   dram_en       bus access enable          (out)
//   dram_wen      bus write enable           (out)
//   dram_addr     word-aligned bus address   (out)
//   dram_wdata    lane-shifted write data    (out)
//   dram_wmask    byte-lane write mask       (out)
//   dram_rdata    combinational read data    (in)
// ---------------------------------------------------------------------------
module lsu_dram_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dram_en,
  output logic              dram_wen,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [31:0]       dram_wdata,
  output logic [3:0]        dram_wmask,
  input  logic [31:0]       dram_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  logic [1:0]        state;
  logic              r_wen;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       lo;
  logic [31:0]       hi;

  // Decode of the incoming request, used only in the accept cycle.
  logic [2:0] in_nbytes;
  logic       in_cross;
  logic       in_err;

  always_comb begin
    case (req_size)
      2'b00:   in_nbytes = 3'd1;
      2'b01:   in_nbytes = 3'd2;
      default: in_nbytes = 3'd4;
    endcase
    // off (max 3) + nbytes (max 4) fits in 3 bits, so no overflow here.
    in_cross = ({1'b0, req_addr[1:0]} + in_nbytes) > 3'd4;
    in_err   = (req_size == 2'b11) | (in_cross & ~SPLIT_EN);
  end

  // Decode of the registered request that drives the bus and the response.
  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [ADDR_W-1:0] base_addr;

  always_comb begin
    off = r_addr[1:0];
    case (r_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    base_addr = {r_addr[ADDR_W-1:2], 2'b00};
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2:0] r_nbytes;
  logic       r_cross;
  logic [2:0] roff;

  always_comb begin
    case (r_size)
      2'b00:   r_nbytes = 3'd1;
      2'b01:   r_nbytes = 3'd2;
      default: r_nbytes = 3'd4;
    endcase
    r_cross = ({1'b0, off} + r_nbytes) > 3'd4;
    // Number of bytes that landed in the first word; the second access
    // shifts mask and data down by that many lanes.
    roff    = 3'd4 - {1'b0, off};
  end
`endif

  // Control FSM and request/data capture. Read data is captured on the
  // edge that ends each access cycle, since the bus returns it
  // combinationally while dram_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_wen      <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      lo         <= '0;
      hi         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_wen      <= req_wen;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_err      <= in_err;
            lo         <= '0;
            hi         <= '0;
            state      <= in_err ? RESP : ACC0;
          end
        end
        ACC0: begin
          lo <= dram_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
          state <= r_cross ? ACC1 : RESP;
`else
          state <= RESP;
`endif
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC1: begin
          hi    <= dram_rdata;
          state <= RESP;
        end
`endif
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are pure decodes of state so that an asynchronous reset
  // drops dram_en at once and an in-flight write never commits.
  always_comb begin
    dram_en    = 1'b0;
    dram_wen   = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    dram_wmask = 4'b0000;
    case (state)
      ACC0: begin
        dram_en    = 1'b1;
        dram_wen   = r_wen;
        dram_addr  = base_addr;
        dram_wmask = size_mask << off;
        dram_wdata = r_wdata << {off, 3'b000};
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        dram_en    = 1'b1;
        dram_wen   = r_wen;
        dram_addr  = base_addr + ADDR_W'(4);
        dram_wmask = size_mask >> roff;
        dram_wdata = r_wdata >> {roff, 3'b000};
      end
`endif
      default: ;
    endcase
  end

  // Load data: realign the captured word pair to the byte offset, then
  // sign- or zero-extend to 32 bits. hi stays 0 for single accesses and
  // non-crossing requests never reach it after the shift.
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    shifted = 32'({hi, lo} >> {off, 3'b000});
    case (r_size)
      2'b00:   load_ext = {{24{~r_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~r_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) & r_err;
  assign resp_rdata = ((state == RESP) && !r_err && !r_wen) ? load_ext : 32'd0;

endmodule
